// File: rtl/divisor_sequencial_pkg.sv
// Shared definitions for the iterative restoring divider.
package divisor_sequencial_pkg;

   localparam int unsigned WIDTH_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } estado_t;

   // Iteration counter must hold WIDTH itself, hence one extra bit.
   function automatic int unsigned countWidth(input int unsigned w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/divisor_passo.sv
// One restoring-division step: shift in the next dividend bit, try to subtract D.
module divisor_passo #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] restoIn,
   input  logic             bitIn,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] restoProx_c,
   output logic             bitQuoc_c
);

   logic [WIDTH:0] trial;

   // Subtract with one extra bit; a set MSB means borrow, so keep the shifted remainder.
   always_comb begin
      trial       = {restoIn, bitIn} - {1'b0, divisor};
      restoProx_c = trial[WIDTH-1:0];
      bitQuoc_c   = 1'b1;
      if (trial[WIDTH]) begin
         restoProx_c = {restoIn[WIDTH-2:0], bitIn};
         bitQuoc_c   = 1'b0;
      end
   end

endmodule

// File: rtl/divisor_sequencial.sv
// Unsigned iterative restoring divider, one quotient bit per clock.
module divisor_sequencial
   import divisor_sequencial_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic [WIDTH-1:0] Dividendo,
   input  logic [WIDTH-1:0] Divisor,
   output logic [WIDTH-1:0] Quociente,
   output logic [WIDTH-1:0] Resto,
   output logic             Pronto,
   output logic             Ocupado,
   output logic             DivZero
);

   localparam int unsigned CW = countWidth(WIDTH);

   estado_t          estado;
   logic [WIDTH-1:0] regR;
   logic [WIDTH-1:0] regQ;
   logic [WIDTH-1:0] regD;
   logic [CW-1:0]    count;

   logic [WIDTH-1:0] restoProx;
   logic             bitQuoc;
   logic [WIDTH-1:0] quocProx;

   divisor_passo #(.WIDTH(WIDTH)) uPasso (
      .restoIn     (regR),
      .bitIn       (regQ[WIDTH-1]),
      .divisor     (regD),
      .restoProx_c (restoProx),
      .bitQuoc_c   (bitQuoc)
   );

   assign quocProx = {regQ[WIDTH-2:0], bitQuoc};

   // Control FSM, datapath registers and registered results.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         estado    <= IDLE;
         regR      <= '0;
         regQ      <= '0;
         regD      <= '0;
         count     <= '0;
         Quociente <= '0;
         Resto     <= '0;
         Pronto    <= 1'b0;
         Ocupado   <= 1'b0;
         DivZero   <= 1'b0;
      end else begin
         Pronto <= 1'b0;
         case (estado)
            IDLE, DONE: begin
               estado <= IDLE;
               if (Start) begin
                  regD    <= Divisor;
                  regQ    <= Dividendo;
                  regR    <= '0;
                  count   <= CW'(WIDTH);
                  DivZero <= 1'b0;
                  if (Divisor == '0) begin
                     // Nothing to iterate: report the fixed divide-by-zero result now.
                     estado    <= DONE;
                     Quociente <= '1;
                     Resto     <= Dividendo;
                     DivZero   <= 1'b1;
                     Pronto    <= 1'b1;
                     Ocupado   <= 1'b0;
                  end else begin
                     estado  <= CALC;
                     Ocupado <= 1'b1;
                  end
               end
            end
            CALC: begin
               regR  <= restoProx;
               regQ  <= quocProx;
               count <= count - CW'(1);
               if (count == CW'(1)) begin
                  Quociente <= quocProx;
                  Resto     <= restoProx;
                  Pronto    <= 1'b1;
                  Ocupado   <= 1'b0;
                  estado    <= DONE;
               end
            end
            default: estado <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divisor_sequencial.sv
// Randomised scoreboard bench for divisor_sequencial.
module tb_divisor_sequencial;

   localparam int unsigned W = 16;

   logic         Clock = 1'b0;
   logic         Reset_n;
   logic         Start;
   logic [W-1:0] Dividendo;
   logic [W-1:0] Divisor;
   logic [W-1:0] Quociente;
   logic [W-1:0] Resto;
   logic         Pronto;
   logic         Ocupado;
   logic         DivZero;

   divisor_sequencial #(.WIDTH(W)) dut (
      .Clock     (Clock),
      .Reset_n   (Reset_n),
      .Start     (Start),
      .Dividendo (Dividendo),
      .Divisor   (Divisor),
      .Quociente (Quociente),
      .Resto     (Resto),
      .Pronto    (Pronto),
      .Ocupado   (Ocupado),
      .DivZero   (DivZero)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           due;
      int           busy;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   busyCnt = 0;

   always @(posedge Clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: plain integer division, fixed result for a zero divisor.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int now);
      exp_t e;
      if (b == 0) begin
         e.q = '1; e.r = a; e.dz = 1'b1; e.due = now + 1; e.busy = 0;
      end else begin
         e.q = a / b; e.r = a % b; e.dz = 1'b0; e.due = now + 1 + W; e.busy = W;
      end
      return e;
   endfunction

   // Called just after a falling edge with the DUT ready to accept on the next rising edge;
   // returns at the falling edge before the DUT can accept again.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
      Start = 1'b1; Dividendo = a; Divisor = b;
      sb.push_back(model(a, b, cyc));
      @(negedge Clock);
      if (!hold) begin
         Start = 1'b0;
         Dividendo = W'($urandom); Divisor = W'($urandom);
      end
      repeat ((b == 0) ? 0 : W - 1 + 1) @(negedge Clock);
   endtask

   // Monitor: every Pronto pops one expectation and checks value, timing and busy span.
   initial begin
      exp_t e;
      forever begin
         @(negedge Clock);
         if (!Reset_n) begin
            busyCnt = 0;
         end else if (Ocupado) begin
            busyCnt++;
         end
         if (Reset_n && Pronto) begin
            if (sb.size() == 0) begin
               check("unexpected_pronto", 32'(Pronto), 32'd0);
            end else begin
               e = sb.pop_front();
               check("quociente", 32'(Quociente), 32'(e.q));
               check("resto",     32'(Resto),     32'(e.r));
               check("divzero",   32'(DivZero),   32'(e.dz));
               check("latency",   32'(cyc),       32'(e.due));
               check("busy_span", 32'(busyCnt),   32'(e.busy));
               check("ocupado_at_pronto", 32'(Ocupado), 32'd0);
            end
            busyCnt = 0;
         end
      end
   end

   initial begin
      int waited;
      logic [W-1:0] pw;
      Reset_n = 1'b0; Start = 1'b0; Dividendo = '0; Divisor = '0;
      repeat (3) @(negedge Clock);
      check("rst_quociente", 32'(Quociente), 32'd0);
      check("rst_resto",     32'(Resto),     32'd0);
      check("rst_pronto",    32'(Pronto),    32'd0);
      check("rst_ocupado",   32'(Ocupado),   32'd0);
      check("rst_divzero",   32'(DivZero),   32'd0);
      Reset_n = 1'b1;
      @(negedge Clock);

      // Directed cases, including zero divisor and recovery from it.
      issue(16'd100, 16'd7, 1'b0);
      issue(16'hFFFF, 16'd1, 1'b0);
      issue(16'd3, 16'd10, 1'b0);
      issue(16'h8000, 16'h8000, 1'b0);
      issue(16'd5, 16'd0, 1'b0);
      issue(16'd9, 16'd2, 1'b0);
      @(negedge Clock);

      // Start re-pulsed mid-calculation must be ignored.
      Start = 1'b1; Dividendo = 16'd50; Divisor = 16'd6;
      sb.push_back(model(16'd50, 16'd6, cyc));
      @(negedge Clock);
      Start = 1'b0;
      repeat (4) @(negedge Clock);
      Start = 1'b1; Dividendo = 16'd200; Divisor = 16'd3;
      @(negedge Clock);
      Start = 1'b0;
      repeat (11) @(negedge Clock);
      @(negedge Clock);

      // Reset in the middle of an operation discards it and clears all outputs.
      Start = 1'b1; Dividendo = 16'd1234; Divisor = 16'd5;
      @(negedge Clock);
      Start = 1'b0;
      repeat (7) @(negedge Clock);
      Reset_n = 1'b0;
      #1;
      check("midrst_quociente", 32'(Quociente), 32'd0);
      check("midrst_resto",     32'(Resto),     32'd0);
      check("midrst_pronto",    32'(Pronto),    32'd0);
      check("midrst_ocupado",   32'(Ocupado),   32'd0);
      check("midrst_divzero",   32'(DivZero),   32'd0);
      @(negedge Clock);
      Reset_n = 1'b1;
      @(negedge Clock);
      issue(16'd1000, 16'd33, 1'b0);

      // Random pairs, isolated transactions.
      for (int i = 0; i < 60; i++) begin
         issue(W'($urandom), ((i % 9) == 0) ? W'(0) : W'($urandom_range(1, 300)), 1'b0);
      end

      // Powers-of-two dividends against sampled divisors, Start held high back-to-back.
      for (int p = 0; p < W; p++) begin
         pw = W'(1) << p;
         issue(pw, 16'd0, 1'b1);
         issue(pw, 16'd1, 1'b1);
         issue(pw, pw, 1'b1);
         issue(pw, 16'hFFFF, 1'b1);
         for (int k = 0; k < 24; k++) begin
            issue(pw, W'($urandom), 1'b1);
         end
      end
      Start = 1'b0;

      waited = 0;
      while (sb.size() != 0 && waited < 100) begin
         @(negedge Clock);
         waited++;
      end
      check("drain_pending", 32'(sb.size()), 32'd0);
      repeat (2) @(negedge Clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
